// File: rtl/sap_core_if.sv
// Request/acknowledge memory port shared by sap_core and its memory.
interface sap_core_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sap_core.sv
// SAP-style accumulator core: FETCH/DECODE/EXEC/HALT FSM driving a req/ack memory port,
// with carry/zero flags, an output register and HALT/resume control.
module sap_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sap_core_if.master        mem,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  input  logic              resume,
  output logic              flag_c,
  output logic              flag_z
);

  if (DATA_W < 8 || DATA_W > 32 || ADDR_W < 4 || ADDR_W > DATA_W - 4) begin : gen_param_check
    $fatal(1, "sap_core: illegal DATA_W/ADDR_W combination");
  end

  localparam logic [3:0] OpLda = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpSta = 4'd4;
  localparam logic [3:0] OpLdi = 4'd5;
  localparam logic [3:0] OpJmp = 4'd6;
  localparam logic [3:0] OpJc  = 4'd7;
  localparam logic [3:0] OpJz  = 4'd8;
  localparam logic [3:0] OpOut = 4'd14;
  localparam logic [3:0] OpHlt = 4'd15;

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q;
  // Only the opcode and operand fields of the instruction word are kept.
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] opd_q;
  logic              flag_c_q, flag_z_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              halted_q;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              is_mem_op;
  logic              jump_taken;
  logic [ADDR_W-1:0] pc_exec;

  assign sum       = {1'b0, a_q} + {1'b0, mem.mem_rdata};
  assign diff      = a_q - mem.mem_rdata;
  assign is_mem_op = op_q inside {OpLda, OpAdd, OpSub, OpSta};

  always_comb begin
    jump_taken = 1'b0;
    case (op_q)
      OpJmp:   jump_taken = 1'b1;
      OpJc:    jump_taken = flag_c_q;
      OpJz:    jump_taken = flag_z_q;
      default: jump_taken = 1'b0;
    endcase
  end

  assign pc_exec = jump_taken ? opd_q : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      a_q         <= '0;
      op_q        <= '0;
      opd_q       <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StFetch: begin
          // The fetch request is normally raised by the previous EXEC; only the
          // first fetch after reset has to raise it here.
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
          end else if (mem.mem_ack) begin
            op_q    <= mem.mem_rdata[DATA_W-1 -: 4];
            opd_q   <= mem.mem_rdata[ADDR_W-1:0];
            pc_q    <= pc_q + 1'b1;
            req_q   <= 1'b0;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (is_mem_op) begin
            req_q   <= 1'b1;
            we_q    <= (op_q == OpSta);
            addr_q  <= opd_q;
            wdata_q <= a_q;
          end
          state_q <= StExec;
        end
        StExec: begin
          if (is_mem_op) begin
            if (mem.mem_ack) begin
              case (op_q)
                OpLda: a_q <= mem.mem_rdata;
                OpAdd: begin
                  {flag_c_q, a_q} <= sum;
                  flag_z_q        <= (sum[DATA_W-1:0] == '0);
                end
                OpSub: begin
                  a_q      <= diff;
                  flag_c_q <= (a_q >= mem.mem_rdata);
                  flag_z_q <= (diff == '0);
                end
                default: ;
              endcase
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= pc_q;
              state_q <= StFetch;
            end
          end else if (op_q == OpHlt) begin
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            case (op_q)
              OpLdi: a_q <= {{(DATA_W - ADDR_W){1'b0}}, opd_q};
              OpOut: begin
                out_data_q  <= a_q;
                out_valid_q <= 1'b1;
              end
              default: ;
            endcase
            pc_q    <= pc_exec;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc_exec;
            state_q <= StFetch;
          end
        end
        StHalt: begin
          if (resume) begin
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= pc_q;
            state_q  <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign halted        = halted_q;
  assign flag_c        = flag_c_q;
  assign flag_z        = flag_z_q;

endmodule

// File: tb/tb_sap_core.sv
// Directed and random-program bench for sap_core: an 8-bit core with a wait-state memory
// and a 16-bit core with zero-wait memory, checked against an instruction-level model.
module tb_sap_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic resume = 1'b0;
  always #5 clk = ~clk;

  sap_core_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();
  sap_core_if #(.DATA_W(16), .ADDR_W(8)) bus16 ();

  logic        out_valid8, halted8, c8, z8;
  logic [7:0]  out_data8;
  logic        out_valid16, halted16, c16, z16;
  logic [15:0] out_data16;
  logic        resume16 = 1'b0;

  sap_core #(.DATA_W(8), .ADDR_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .mem(bus8), .out_valid(out_valid8), .out_data(out_data8),
    .halted(halted8), .resume(resume), .flag_c(c8), .flag_z(z8)
  );

  sap_core #(.DATA_W(16), .ADDR_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .mem(bus16), .out_valid(out_valid16), .out_data(out_data16),
    .halted(halted16), .resume(resume16), .flag_c(c16), .flag_z(z16)
  );

  // Memories: w8 wait cycles before each ack on the 8-bit port, zero-wait on the 16-bit one.
  logic [7:0]  mem8 [16];
  logic [7:0]  img8 [16];
  logic [15:0] mem16 [256];
  logic [15:0] img16 [256];
  logic        load = 1'b0;
  int unsigned w8 = 0;
  int unsigned cnt8;
  int          wr8 = 0;

  assign bus8.mem_rdata  = mem8[bus8.mem_addr];
  assign bus8.mem_ack    = bus8.mem_req && (cnt8 == w8);
  assign bus16.mem_rdata = mem16[bus16.mem_addr];
  assign bus16.mem_ack   = bus16.mem_req;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt8 <= 0;
    else if (bus8.mem_req && bus8.mem_ack) cnt8 <= 0;
    else if (bus8.mem_req) cnt8 <= cnt8 + 1;
  end

  always @(posedge clk) begin
    if (load) begin
      mem8  <= img8;
      mem16 <= img16;
    end else if (rst_n) begin
      if (bus8.mem_req && bus8.mem_ack && bus8.mem_we) begin
        mem8[bus8.mem_addr] <= bus8.mem_wdata;
        wr8 <= wr8 + 1;
      end
      if (bus16.mem_req && bus16.mem_ack && bus16.mem_we)
        mem16[bus16.mem_addr] <= bus16.mem_wdata;
    end
  end

  // Observers on the falling edge: output pulses, completed reads, request stability.
  logic [7:0] out_log8[$];
  int         rd_log8[$];
  int         stab_err = 0;
  logic       p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [3:0] p_addr = '0;
  logic [7:0] p_wd = '0;

  always @(negedge clk) begin
    if (out_valid8) out_log8.push_back(out_data8);
    if (bus8.mem_req && bus8.mem_ack && !bus8.mem_we) rd_log8.push_back(int'(bus8.mem_addr));
    if (rst_n && p_req && !p_ack &&
        (!bus8.mem_req || bus8.mem_we !== p_we || bus8.mem_addr !== p_addr ||
         bus8.mem_wdata !== p_wd))
      stab_err <= stab_err + 1;
    p_req  <= bus8.mem_req && rst_n;
    p_ack  <= bus8.mem_ack;
    p_we   <= bus8.mem_we;
    p_addr <= bus8.mem_addr;
    p_wd   <= bus8.mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_img();
    foreach (img8[i]) img8[i] = '0;
    foreach (img16[i]) img16[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int limit, output int cyc);
    cyc = 0;
    while (!halted8 && cyc < limit) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic check_reads(input string tag, input int base, input int exp[$]);
    check({tag, "_nreads"}, 64'(rd_log8.size() - base), 64'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < rd_log8.size(); i++)
      check(tag, 64'(rd_log8[base + i]), 64'(exp[i]));
  endtask

  int cyc, ob, rb, wb;
  int m[16];
  int pc, a, c, z, ecyc, ewr, ins, op, opd;
  int exp_out[$];
  int unsigned rop, ropd;

  initial begin
    // Reference program run on both widths, followed by a resume/wrap continuation.
    clear_img();
    img8[0] = 8'h1E; img8[1] = 8'h2F; img8[2] = 8'hE0; img8[3] = 8'hF0;
    img8[4] = 8'hE0; img8[5] = 8'hF0; img8[6] = 8'h6F;
    img8[14] = 8'd28; img8[15] = 8'd14;
    img16[0] = 16'h10C8; img16[1] = 16'h20C9; img16[2] = 16'hE000; img16[3] = 16'hF000;
    img16[200] = 16'd30000; img16[201] = 16'd35536;
    rst_n = 1'b0;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    check("rst_req",       64'(bus8.mem_req), 64'd0);
    check("rst_halted",    64'(halted8), 64'd0);
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_out_data",  64'(out_data8), 64'd0);
    check("rst_flags",     64'({c8, z8}), 64'd0);
    check("rst_req16",     64'(bus16.mem_req), 64'd0);
    tick(1);
    rst_n = 1'b1;
    ob = out_log8.size();
    tick(1);
    check("first_req",  64'(bus8.mem_req), 64'd1);
    check("first_addr", 64'(bus8.mem_addr), 64'd0);
    check("first_we",   64'(bus8.mem_we), 64'd0);
    run_to_halt(100, cyc);
    check("a_halted",     64'(halted8), 64'd1);
    check("a_latency",    64'(cyc + 1), 64'd13);
    check("a_out_data",   64'(out_data8), 64'd42);
    check("a_out_pulses", 64'(out_log8.size() - ob), 64'd1);
    check("a_flags",      64'({c8, z8}), 64'b00);
    check("a_halt_req",   64'(bus8.mem_req), 64'd0);
    check("w16_halted",   64'(halted16), 64'd1);
    check("w16_out",      64'(out_data16), 64'd0);
    check("w16_flags",    64'({c16, z16}), 64'b11);

    // Resume held 4 cycles restarts once at PC 4 (OUT, HLT).
    ob = out_log8.size();
    resume = 1'b1;
    tick(4);
    resume = 1'b0;
    run_to_halt(50, cyc);
    check("b_halted", 64'(halted8), 64'd1);
    check("b_cycles", 64'(cyc), 64'd3);
    check("b_pulses", 64'(out_log8.size() - ob), 64'd1);
    tick(5);
    check("b_stay_halted", 64'(halted8), 64'd1);
    check("b_halt_noreq",  64'(bus8.mem_req), 64'd0);

    // JMP 15, NOP at 15 wraps the fetch to 0; a resume pulse while running is ignored.
    rb = rd_log8.size();
    ob = out_log8.size();
    resume = 1'b1;
    tick(1);
    resume = 1'b0;
    tick(2);
    resume = 1'b1;
    tick(1);
    resume = 1'b0;
    run_to_halt(100, cyc);
    check("wrap_halted", 64'(halted8), 64'd1);
    check_reads("wrap_read", rb, '{6, 15, 0, 14, 1, 15, 2, 3});
    check("wrap_out", 64'(out_data8), 64'd42);
    check("wrap_pulses", 64'(out_log8.size() - ob), 64'd1);

    // LDI 10, SUB 15 (=10), JZ 9 taken, JC never fetched.
    clear_img();
    img8[0] = 8'h5A; img8[1] = 8'h3F; img8[2] = 8'h89; img8[3] = 8'h79;
    img8[9] = 8'hE0; img8[10] = 8'hF0; img8[15] = 8'd10;
    do_reset();
    rb = rd_log8.size();
    run_to_halt(100, cyc);
    check("jz_cycles", 64'(cyc), 64'd16);
    check_reads("jz_read", rb, '{0, 1, 15, 2, 9, 10});
    check("jz_a", 64'(out_data8), 64'd0);
    check("jz_flags", 64'({c8, z8}), 64'b11);

    // 200 + 100 wraps to 44 with carry; following JC is taken.
    clear_img();
    img8[0] = 8'h1D; img8[1] = 8'h2E; img8[2] = 8'h78; img8[3] = 8'hF0;
    img8[8] = 8'hE0; img8[9] = 8'hF0; img8[13] = 8'd200; img8[14] = 8'd100;
    do_reset();
    rb = rd_log8.size();
    run_to_halt(100, cyc);
    check_reads("jc_read", rb, '{0, 13, 1, 14, 2, 8, 9});
    check("jc_a", 64'(out_data8), 64'd44);
    check("jc_flags", 64'({c8, z8}), 64'b10);

    // Three wait cycles on every request.
    clear_img();
    w8 = 3;
    img8[0] = 8'h1E; img8[1] = 8'h4D; img8[2] = 8'hE0; img8[3] = 8'hF0; img8[14] = 8'd77;
    do_reset();
    wb = wr8;
    ob = out_log8.size();
    tick(9);
    check("wait_lda_req",  64'(bus8.mem_req), 64'd1);
    check("wait_lda_addr", 64'(bus8.mem_addr), 64'd14);
    tick(1);
    check("wait_next_fetch", 64'(bus8.mem_addr), 64'd1);
    run_to_halt(200, cyc);
    check("wait_latency", 64'(cyc + 10), 64'd31);
    check("wait_mem13", 64'(mem8[13]), 64'd77);
    check("wait_writes", 64'(wr8 - wb), 64'd1);
    check("wait_pulses", 64'(out_log8.size() - ob), 64'd1);
    check("wait_out", 64'(out_data8), 64'd77);
    check("wait_stable", 64'(stab_err), 64'd0);

    // Reset in the middle of a delayed STA.
    clear_img();
    img8[0] = 8'h57; img8[1] = 8'h4C; img8[2] = 8'hF0; img8[12] = 8'h55;
    do_reset();
    wb = wr8;
    tick(12);
    check("sta_req", 64'({bus8.mem_req, bus8.mem_we, bus8.mem_addr}), 64'({1'b1, 1'b1, 4'd12}));
    check("sta_wdata", 64'(bus8.mem_wdata), 64'd7);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 64'({bus8.mem_req, bus8.mem_we}), 64'd0);
    check("async_bus", 64'({bus8.mem_addr, bus8.mem_wdata}), 64'd0);
    tick(2);
    check("async_mem", 64'(mem8[12]), 64'h55);
    check("async_writes", 64'(wr8 - wb), 64'd0);
    rst_n = 1'b1;
    tick(1);
    check("refetch", 64'({bus8.mem_req, bus8.mem_we, bus8.mem_addr}), 64'({1'b1, 1'b0, 4'd0}));

    // Random forward-only programs against the instruction-level model.
    for (int k = 0; k < 6; k++) begin
      clear_img();
      w8 = $urandom_range(0, 2);
      for (int i = 0; i < 11; i++) begin
        rop = $urandom_range(0, 14);
        if (rop >= 1 && rop <= 4) ropd = $urandom_range(12, 15);
        else if (rop >= 6 && rop <= 8) ropd = $urandom_range(i + 1, 11);
        else ropd = $urandom_range(0, 15);
        img8[i] = 8'(rop * 16 + ropd);
      end
      img8[11] = 8'hF0;
      for (int i = 12; i < 16; i++) img8[i] = 8'($urandom_range(0, 255));

      foreach (m[i]) m[i] = int'(img8[i]);
      pc = 0; a = 0; c = 0; z = 0; ecyc = 1; ewr = 0;
      exp_out.delete();
      for (int step = 0; step < 64; step++) begin
        ins  = m[pc];
        op   = ins / 16;
        opd  = ins % 16;
        pc   = (pc + 1) % 16;
        ecyc = ecyc + 3 + int'(w8) + ((op >= 1 && op <= 4) ? int'(w8) : 0);
        if (op == 15) break;
        case (op)
          1: a = m[opd];
          2: begin a = a + m[opd]; c = (a > 255) ? 1 : 0; a = a % 256; z = (a == 0) ? 1 : 0; end
          3: begin
            c = (a >= m[opd]) ? 1 : 0;
            a = (a - m[opd] + 256) % 256;
            z = (a == 0) ? 1 : 0;
          end
          4: begin m[opd] = a; ewr++; end
          5: a = opd;
          6: pc = opd;
          7: if (c != 0) pc = opd;
          8: if (z != 0) pc = opd;
          14: exp_out.push_back(a);
          default: ;
        endcase
      end

      do_reset();
      ob = out_log8.size();
      wb = wr8;
      run_to_halt(500, cyc);
      check("rnd_halted", 64'(halted8), 64'd1);
      check("rnd_cycles", 64'(cyc), 64'(ecyc));
      check("rnd_npulses", 64'(out_log8.size() - ob), 64'(exp_out.size()));
      for (int i = 0; i < exp_out.size() && ob + i < out_log8.size(); i++)
        check("rnd_out", 64'(out_log8[ob + i]), 64'(exp_out[i]));
      check("rnd_flags", 64'({c8, z8}), 64'({c[0], z[0]}));
      check("rnd_writes", 64'(wr8 - wb), 64'(ewr));
      for (int i = 12; i < 16; i++) check("rnd_mem", 64'(mem8[i]), 64'(m[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_core.md
SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: datapath and instruction word width, legal range 8..32.
REQ-002 SHALL have parameter ADDR_W, default 4: memory address width, legal range 4..DATA_W-4; out-of-range values SHALL be rejected at elaboration.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 mem_req  output  1  memory request, held until acknowledged.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  ADDR_W  request address.
REQ-008 mem_wdata  output  DATA_W  write data (register A).
REQ-009 mem_rdata  input  DATA_W  read data, valid in the cycle mem_ack=1.
REQ-010 mem_ack  input  1  completes the current request; may be high in the same cycle mem_req rises.
REQ-011 out_valid  output  1  one-cycle pulse, out_data updated.
REQ-012 out_data  output  DATA_W  output register.
REQ-013 halted  output  1  core is in HALT.
REQ-014 resume  input  1  leave HALT.
REQ-015 flag_c, flag_z  output  1 each  carry and zero flag registers.

Function
REQ-016 Instruction word: opcode = bits [DATA_W-1:DATA_W-4], operand = bits [ADDR_W-1:0]; remaining bits ignored.
REQ-017 Opcodes: 0 NOP; 1 LDA A<=M[op]; 2 ADD A<=A+M[op]; 3 SUB A<=A-M[op]; 4 STA M[op]<=A; 5 LDI A<=zero-extended op; 6 JMP; 7 JC (jump if flag_c); 8 JZ (jump if flag_z); 14 OUT; 15 HLT; all other opcodes SHALL execute as NOP.
REQ-018 FSM states: FETCH, DECODE, EXEC, HALT. Transitions: FETCH->DECODE on mem_ack; DECODE->EXEC; EXEC->FETCH on completion; EXEC->HALT for HLT; HALT->FETCH on resume.
REQ-019 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC; on mem_ack the core SHALL latch IR<=mem_rdata and set PC<=PC+1 modulo 2^ADDR_W.
REQ-020 In EXEC, LDA/ADD/SUB SHALL issue a read and STA a write at operand, holding mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack; EXEC ends in the ack cycle.
REQ-021 All other opcodes SHALL complete EXEC in exactly one cycle. With zero-wait memory every instruction SHALL take 3 cycles; each wait cycle adds 1.
REQ-022 ADD: flag_c = carry out of bit DATA_W-1. SUB: flag_c = 1 when A >= M (no borrow). Both: flag_z = (DATA_W-bit result == 0); result truncated to DATA_W.
REQ-023 Flags SHALL change only on ADD and SUB.
REQ-024 A taken jump SHALL load PC<=operand; a not-taken conditional jump leaves PC unchanged.
REQ-025 OUT: out_data<=A with out_valid=1 for exactly one cycle; out_data SHALL hold until the next OUT.
REQ-026 HLT: halted=1 from the cycle after EXEC; PC already points past HLT; mem_req=0 in HALT.
REQ-027 resume SHALL be ignored outside HALT; in HALT a 1 SHALL move the core to FETCH on the next edge.
REQ-028 mem_req SHALL be 0 in DECODE, HALT and non-memory EXEC.

Reset
REQ-029 rst_n=0 SHALL immediately clear PC, A, IR, flag_c, flag_z, out_data, out_valid, mem_req, mem_we, mem_addr, mem_wdata, halted and set state FETCH, including mid-transaction.
REQ-030 After rst_n rises, the first mem_req (address 0) SHALL appear on the first clock edge.

Verification
REQ-031 DATA_W=8, ADDR_W=4, zero-wait; program LDA 14, ADD 15, OUT, HLT, M[14]=28, M[15]=14 -> out_data=42, one out_valid pulse, flag_c=0, flag_z=0, halted=1 after 12 cycles.
REQ-032 LDI 10, SUB 15 with M[15]=10, JZ 9, JC 9 -> A=0, flag_z=1, flag_c=1, PC=9 after the JZ; the JC is never fetched. Separately, A=200 plus M=100 -> A=44, flag_c=1, and a following JC is taken.
REQ-033 mem_ack delayed 3 cycles on every request -> mem_req/mem_addr stable throughout; LDA takes 9 cycles; no duplicate side effects.
REQ-034 JMP 15 with NOP at 15 -> next fetch address 0 (wrap). HLT, then resume held 4 cycles -> exactly one restart; pulses outside HALT ignored.
REQ-035 rst_n low during a delayed STA -> mem_req=0 immediately, memory unchanged, refetch from address 0. Repeat REQ-031 at DATA_W=16, ADDR_W=8 with operands 30000+35536 -> A=0, flag_c=1, flag_z=1.
